// File: rtl/wave_generator.sv
// Phase-accumulator oscillator: square/saw/triangle from the top byte of the phase.
// A requested mode takes effect only when the phase wraps, so a period never glitches.
module wave_generator #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [ACC_W-1:0] tone_inc,
  input  logic             sample_tick,
  output logic [7:0]       sample,
  output logic             sample_valid,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SQUARE = 2'b01,
    MODE_SAW    = 2'b10,
    MODE_TRI    = 2'b11
  } mode_e;

  logic [ACC_W-1:0] phase_q, phase_d;
  mode_e            act_mode_q, act_mode_d;
  logic             carry_q, carry_d;
  logic             tick_q;
  logic [7:0]       sample_q, sample_d;
  logic             valid_q;
  logic             wrap_q;

  logic [ACC_W:0]   sum;
  logic [7:0]       p;
  logic [7:0]       tri_t;

  assign sum = {1'b0, phase_q} + {1'b0, tone_inc};

  always_comb begin
    phase_d    = phase_q;
    act_mode_d = act_mode_q;
    carry_d    = 1'b0;
    if (sample_tick) begin
      if (act_mode_q == MODE_OFF && mode != 2'b00) begin
        act_mode_d = mode_e'(mode);
        phase_d    = tone_inc;
      end else if (act_mode_q == MODE_OFF) begin
        phase_d = '0;
      end else if (tone_inc == '0) begin
        // Frozen phase can never wrap, so the new mode is applied right away.
        act_mode_d = mode_e'(mode);
      end else begin
        phase_d = sum[ACC_W-1:0];
        carry_d = sum[ACC_W];
        if (sum[ACC_W]) act_mode_d = mode_e'(mode);
      end
    end
  end

  assign p     = phase_q[ACC_W-1 -: 8];
  assign tri_t = {p[6:0], 1'b0};

  always_comb begin
    sample_d = 8'h00;
    case (act_mode_q)
      MODE_OFF:    sample_d = 8'h00;
      MODE_SQUARE: sample_d = p[7] ? 8'h00 : 8'hFF;
      MODE_SAW:    sample_d = p;
      MODE_TRI:    sample_d = p[7] ? ~tri_t : tri_t;
      default:     sample_d = 8'h00;
    endcase
  end

  // Stage 1: phase and active mode advance on the tick edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      act_mode_q <= MODE_OFF;
      carry_q    <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      act_mode_q <= act_mode_d;
      carry_q    <= carry_d;
      tick_q     <= sample_tick;
    end
  end

  // Stage 2: waveform shaped from the updated phase and presented one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= 8'h00;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      valid_q <= tick_q;
      if (tick_q) begin
        sample_q <= sample_d;
        wrap_q   <= carry_q;
      end else begin
        wrap_q   <= 1'b0;
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_wave_generator.sv
// Scoreboard bench for wave_generator: each tick pushes its expected sample/wrap
// and due cycle; the negedge monitor pops one entry per sample_valid pulse.
module tb_wave_generator;

  localparam int ACC_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [ACC_W-1:0] tone_inc = '0;
  logic             sample_tick = 1'b0;
  logic [7:0]       sample;
  logic             sample_valid;
  logic             wrap;

  typedef struct {
    logic [7:0] smp;
    logic       wr;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  wave_generator #(.ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .tone_inc     (tone_inc),
    .sample_tick  (sample_tick),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding tick.
  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sample", {24'd0, sample}, {24'd0, e.smp});
        check_eq("wrap", {31'd0, wrap}, {31'd0, e.wr});
        check_eq("latency", cyc, e.due);
      end
    end
  end

  task automatic do_tick(input logic [1:0] m, input logic [15:0] inc,
                         input logic [7:0] es, input logic ew);
    exp_t e;
    @(negedge clk);
    mode        = m;
    tone_inc    = inc;
    sample_tick = 1'b1;
    e.smp = es;
    e.wr  = ew;
    e.due = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  task automatic drain_and_reset();
    int budget;
    gap(1);
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check_eq("drained", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_sample", {24'd0, sample}, 32'h00);
    check_eq("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("rst_wrap", {31'd0, wrap}, 32'd0);
    rst = 1'b0;

    // Saw ramp with varied spacing between ticks
    for (int i = 0; i < 16; i++) begin
      do_tick(2'b10, 16'h1000, 8'((i + 1) * 16), (i == 15));
      gap(i % 3);
    end
    drain_and_reset();

    // Square
    do_tick(2'b01, 16'h4000, 8'hFF, 1'b0); gap(1);
    do_tick(2'b01, 16'h4000, 8'h00, 1'b0); gap(1);
    do_tick(2'b01, 16'h4000, 8'h00, 1'b0); gap(1);
    do_tick(2'b01, 16'h4000, 8'hFF, 1'b1);
    drain_and_reset();

    // Triangle
    do_tick(2'b11, 16'h4000, 8'h80, 1'b0); gap(2);
    do_tick(2'b11, 16'h4000, 8'hFF, 1'b0); gap(2);
    do_tick(2'b11, 16'h4000, 8'h7F, 1'b0); gap(2);
    do_tick(2'b11, 16'h4000, 8'h00, 1'b1);
    drain_and_reset();

    // Deferred mode change: triangle only after the wrap
    do_tick(2'b10, 16'h4000, 8'h40, 1'b0); gap(1);
    do_tick(2'b10, 16'h4000, 8'h80, 1'b0); gap(1);
    do_tick(2'b11, 16'h4000, 8'hC0, 1'b0); gap(1);
    do_tick(2'b11, 16'h4000, 8'h00, 1'b1); gap(1);
    do_tick(2'b11, 16'h4000, 8'h80, 1'b0);
    drain_and_reset();

    // Off via wrap, then held silent
    do_tick(2'b10, 16'h4000, 8'h40, 1'b0); gap(1);
    do_tick(2'b10, 16'h4000, 8'h80, 1'b0); gap(1);
    do_tick(2'b00, 16'h4000, 8'hC0, 1'b0); gap(1);
    do_tick(2'b00, 16'h4000, 8'h00, 1'b1); gap(1);
    do_tick(2'b00, 16'h4000, 8'h00, 1'b0); gap(1);
    do_tick(2'b00, 16'h4000, 8'h00, 1'b0);
    drain_and_reset();

    // Frozen phase: mode applies immediately, never wraps
    do_tick(2'b10, 16'h4000, 8'h40, 1'b0); gap(1);
    do_tick(2'b01, 16'h0000, 8'hFF, 1'b0); gap(1);
    do_tick(2'b11, 16'h0000, 8'h80, 1'b0);
    gap(4);
    check_eq("hold_sample", {24'd0, sample}, 32'h80);
    check_eq("hold_valid", {31'd0, sample_valid}, 32'd0);
    drain_and_reset();

    // Back-to-back ticks
    for (int i = 0; i < 8; i++) begin
      do_tick(2'b10, 16'h2000, 8'((i + 1) * 32), (i == 7));
    end
    drain_and_reset();

    // Reset mid-run discards the in-flight tick
    do_tick(2'b10, 16'h1000, 8'h10, 1'b0); gap(1);
    do_tick(2'b10, 16'h1000, 8'h20, 1'b0); gap(3);
    do_tick(2'b10, 16'h1000, 8'h30, 1'b0);
    @(posedge clk);
    #2;
    sample_tick = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_sample", {24'd0, sample}, 32'h00);
    check_eq("midrst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("midrst_wrap", {31'd0, wrap}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_tick(2'b10, 16'h1000, 8'h10, 1'b0);
    gap(1);
    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      check_eq("final_drained", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
